// File: rtl/decode_stage_p.sv
// ID stage: control decode, 2R/1W register file with write-through bypass, immediate sign-extension,
// and an ID/EX pipeline register with valid/ready handshake, stall, flush and load-use interlock.
module decode_stage_p #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] read1data,
  output logic [XLEN-1:0] read2data,
  output logic [XLEN-1:0] imm_ext,
  output logic [3:0]      alu_op,
  output logic            imm_sel,
  output logic            wb_sel,
  output logic            write,
  output logic [1:0]      branch,
  output logic [4:0]      rd_q
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [6:0]    op;
  logic [RW-1:0] wb_idx;
  logic [1:0][RW-1:0]   rs_sel;
  logic [1:0][XLEN-1:0] rd_val;
  assign op        = instr[31:25];
  assign rs_sel[0] = instr[15 +: RW];
  assign rs_sel[1] = instr[10 +: RW];
  assign wb_idx    = wb_rd[RW-1:0];

  // Opcode classes on op[6:4]: 0 reg-reg, 1 reg-imm, 2 load, 3 store, 4 cond branch, 5 jump-and-link.
  logic [3:0] ctl_alu_op;
  logic       ctl_imm_sel, ctl_wb_sel, ctl_write;
  logic [1:0] ctl_branch;
  always_comb begin
    ctl_alu_op  = 4'd0;
    ctl_imm_sel = 1'b0;
    ctl_wb_sel  = 1'b0;
    ctl_write   = 1'b0;
    ctl_branch  = 2'b00;
    case (op[6:4])
      3'd0: begin ctl_write = 1'b1; ctl_alu_op = op[3:0]; end
      3'd1: begin ctl_write = 1'b1; ctl_imm_sel = 1'b1; ctl_alu_op = op[3:0]; end
      3'd2: begin ctl_write = 1'b1; ctl_imm_sel = 1'b1; ctl_wb_sel = 1'b1; end
      3'd3: ctl_imm_sel = 1'b1;
      3'd4: begin ctl_branch = 2'b01; ctl_alu_op = op[3:0]; end
      3'd5: begin ctl_branch = 2'b11; ctl_write = 1'b1; ctl_imm_sel = 1'b1; end
      default: ;
    endcase
  end

  logic [14:0]     imm_raw;
  logic [XLEN-1:0] imm_sx;
  assign imm_raw = ctl_branch[0] ? {instr[24:20], instr[9:0]} : instr[14:0];
  assign imm_sx  = {{(XLEN-15){imm_raw[14]}}, imm_raw};

  // Register file; r0 is never written when hard-wired to zero, so it stays at its reset value.
  logic            wb_ok;
  logic [XLEN-1:0] rf_q [NREG];
  assign wb_ok = wb_en && !(ZERO_R0 && (wb_idx == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_ok) begin
      rf_q[wb_idx] <= wb_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      assign rd_val[gi] = (ZERO_R0 && (rs_sel[gi] == '0)) ? '0 :
                          (wb_ok && (wb_idx == rs_sel[gi])) ? wb_data : rf_q[rs_sel[gi]];
    end
  endgenerate

  logic            ex_valid_reg, write_reg, wb_sel_reg, imm_sel_reg;
  logic [1:0]      branch_reg;
  logic [3:0]      alu_op_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] read1_reg, read2_reg, imm_reg;
  logic            lu, adv;

  assign lu = ex_valid_reg && write_reg && wb_sel_reg && (rd_reg != 5'd0) &&
              ((rd_reg[RW-1:0] == rs_sel[0]) || (rd_reg[RW-1:0] == rs_sel[1]));
  assign adv      = !ex_valid_reg || ex_ready;
  assign id_ready = adv && !lu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg <= 1'b0;
      write_reg    <= 1'b0;
      branch_reg   <= 2'b00;
      wb_sel_reg   <= 1'b0;
      imm_sel_reg  <= 1'b0;
      alu_op_reg   <= 4'd0;
      rd_reg       <= 5'd0;
      read1_reg    <= '0;
      read2_reg    <= '0;
      imm_reg      <= '0;
    end else if (flush || (adv && (lu || !id_valid))) begin
      // Flush, load-use bubble and idle all kill just the fields that could cause side effects.
      ex_valid_reg <= 1'b0;
      write_reg    <= 1'b0;
      branch_reg   <= 2'b00;
    end else if (adv) begin
      ex_valid_reg <= 1'b1;
      write_reg    <= ctl_write;
      branch_reg   <= ctl_branch;
      wb_sel_reg   <= ctl_wb_sel;
      imm_sel_reg  <= ctl_imm_sel;
      alu_op_reg   <= ctl_alu_op;
      rd_reg       <= instr[24:20];
      read1_reg    <= rd_val[0];
      read2_reg    <= rd_val[1];
      imm_reg      <= imm_sx;
    end
  end

  assign ex_valid  = ex_valid_reg;
  assign write     = write_reg;
  assign branch    = branch_reg;
  assign wb_sel    = wb_sel_reg;
  assign imm_sel   = imm_sel_reg;
  assign alu_op    = alu_op_reg;
  assign rd_q      = rd_reg;
  assign read1data = read1_reg;
  assign read2data = read2_reg;
  assign imm_ext   = imm_reg;
endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboard bench for decode_stage_p: the driver queues expected ID/EX contents on acceptance,
// a negedge monitor pops and compares on every EX transfer.
module tb_decode_stage_p;
  logic        clk, rst_n, flush, id_valid, id_ready, wb_en, ex_ready, ex_valid;
  logic [31:0] instr, wb_data, read1data, read2data, imm_ext;
  logic [4:0]  wb_rd, rd_q;
  logic [3:0]  alu_op;
  logic        imm_sel, wb_sel, write;
  logic [1:0]  branch;

  decode_stage_p #(.XLEN(32), .NREG(32), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .instr(instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .read1data(read1data), .read2data(read2data), .imm_ext(imm_ext),
    .alu_op(alu_op), .imm_sel(imm_sel), .wb_sel(wb_sel), .write(write), .branch(branch),
    .rd_q(rd_q)
  );

  typedef struct packed {
    logic [31:0] r1, r2, imm;
    logic [3:0]  alu;
    logic        isel, wsel, wr;
    logic [1:0]  br;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_a;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                      logic [4:0] rs2, logic [9:0] i10);
    return {op, rd, rs1, rs2, i10};
  endfunction

  function automatic exp_t ex(logic [31:0] r1, logic [31:0] r2, logic [31:0] imm, logic [3:0] alu,
                              logic isel, logic wsel, logic wr, logic [1:0] br, logic [4:0] rd);
    return {r1, r2, imm, alu, isel, wsel, wr, br, rd};
  endfunction

  function automatic exp_t cur();
    return {read1data, read2data, imm_ext, alu_op, imm_sel, wb_sel, write, branch, rd_q};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Presents one instruction until accepted; reports how many cycles it was held off.
  task automatic send(input string name, input logic [31:0] i, input exp_t e, input int exp_wait);
    int  waits = 0;
    bit  acc   = 1'b0;
    instr    = i;
    id_valid = 1'b1;
    while (!acc && waits < 20) begin
      @(negedge clk);
      acc = id_ready;
      if (acc) sb.push_back(e);
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    id_valid = 1'b0;
    wb_en    = 1'b0;
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL %s: not accepted within 20 cycles", name);
    end else begin
      chk({name, "_wait"}, 64'(waits), 64'(exp_wait));
    end
    $display("[TB] issue %-10s instr=%h waits=%0d", name, i, waits);
  endtask

  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL idex_unexpected: rd=%0d with no expectation queued", rd_q);
      end else begin
        mon_e = sb.pop_front();
        mon_a = cur();
        n_pop++;
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL idex[%0d]: got r1=%h r2=%h imm=%h alu=%h is/ws/wr=%b%b%b br=%b rd=%0d expected r1=%h r2=%h imm=%h alu=%h is/ws/wr=%b%b%b br=%b rd=%0d",
                   n_pop, mon_a.r1, mon_a.r2, mon_a.imm, mon_a.alu, mon_a.isel, mon_a.wsel, mon_a.wr,
                   mon_a.br, mon_a.rd, mon_e.r1, mon_e.r2, mon_e.imm, mon_e.alu, mon_e.isel,
                   mon_e.wsel, mon_e.wr, mon_e.br, mon_e.rd);
        end else begin
          $display("[TB] retire #%0d rd=%0d r1=%h r2=%h imm=%h", n_pop, rd_q, read1data, read2data, imm_ext);
        end
      end
    end
  end

  initial begin
    exp_t ex_x;
    int   k;
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; instr = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
    #1;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_idex", 64'({read1data, alu_op, imm_sel, wb_sel, write, branch, rd_q}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Same-cycle writeback bypass on both read ports, then plain RF reads.
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    send("bypass1", ins(7'h03, 5'd1, 5'd5, 5'd0, 10'd0), ex(32'hDEADBEEF, 0, 0, 4'd3, 0, 0, 1, 2'b00, 5'd1), 0);
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h12345678;
    send("bypass2", ins(7'h11, 5'd2, 5'd5, 5'd3, 10'h3FF), ex(32'hDEADBEEF, 32'h12345678, 32'h00000FFF, 4'd1, 1, 0, 1, 2'b00, 5'd2), 0);
    send("rr", ins(7'h02, 5'd4, 5'd3, 5'd5, 10'd0), ex(32'h12345678, 32'hDEADBEEF, 32'h00001400, 4'd2, 0, 0, 1, 2'b00, 5'd4), 0);
    send("imm_neg", ins(7'h16, 5'd6, 5'd0, 5'd31, 10'd0), ex(0, 0, 32'hFFFFFC00, 4'd6, 1, 0, 1, 2'b00, 5'd6), 0);
    send("branch", ins(7'h40, 5'h10, 5'd3, 5'd5, 10'd0), ex(32'h12345678, 32'hDEADBEEF, 32'hFFFFC000, 4'd0, 0, 0, 0, 2'b01, 5'd16), 0);
    send("jump", ins(7'h50, 5'd1, 5'd0, 5'd0, 10'd5), ex(0, 0, 32'h00000405, 4'd0, 1, 0, 1, 2'b11, 5'd1), 0);

    // r0 ignores writes, including the bypass path.
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    send("r0_byp", ins(7'h00, 5'd10, 5'd0, 5'd0, 10'd0), ex(0, 0, 0, 4'd0, 0, 0, 1, 2'b00, 5'd10), 0);
    send("r0_read", ins(7'h00, 5'd11, 5'd0, 5'd5, 10'd0), ex(0, 32'hDEADBEEF, 32'h00001400, 4'd0, 0, 0, 1, 2'b00, 5'd11), 0);

    // Load-use costs exactly one bubble; an unrelated consumer costs none.
    send("load7", ins(7'h20, 5'd7, 5'd3, 5'd0, 10'd4), ex(32'h12345678, 0, 32'd4, 4'd0, 1, 1, 1, 2'b00, 5'd7), 0);
    send("use_r7", ins(7'h01, 5'd8, 5'd3, 5'd7, 10'd0), ex(32'h12345678, 0, 32'h00001C00, 4'd1, 0, 0, 1, 2'b00, 5'd8), 1);
    send("load12", ins(7'h20, 5'd12, 5'd5, 5'd0, 10'd8), ex(32'hDEADBEEF, 0, 32'd8, 4'd0, 1, 1, 1, 2'b00, 5'd12), 0);
    send("no_dep", ins(7'h00, 5'd13, 5'd5, 5'd3, 10'd0), ex(32'hDEADBEEF, 32'h12345678, 32'h00000C00, 4'd0, 0, 0, 1, 2'b00, 5'd13), 0);

    // Downstream stall: ID/EX contents hold and ID refuses new work.
    ex_x = ex(32'h12345678, 32'h12345678, 32'h00000C00, 4'd4, 0, 0, 1, 2'b00, 5'd9);
    send("stall_x", ins(7'h04, 5'd9, 5'd3, 5'd3, 10'd0), ex_x, 0);
    ex_ready = 1'b0;
    instr = ins(7'h05, 5'd14, 5'd5, 5'd0, 10'd0); id_valid = 1'b1;
    for (k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_id_ready", 64'(id_ready), 64'd0);
      chk("stall_ex_valid", 64'(ex_valid), 64'd1);
      chk("stall_hold", 64'(cur().r1 ^ {27'd0, cur().rd} ^ {28'd0, cur().alu}), 64'(ex_x.r1 ^ {27'd0, ex_x.rd} ^ {28'd0, ex_x.alu}));
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    send("resume", ins(7'h05, 5'd14, 5'd5, 5'd0, 10'd0), ex(32'hDEADBEEF, 0, 0, 4'd5, 0, 0, 1, 2'b00, 5'd14), 0);

    // Flush while stalled kills the held instruction.
    send("flush_z", ins(7'h50, 5'd2, 5'd0, 5'd0, 10'd0), ex(0, 0, 32'h00000800, 4'd0, 1, 0, 1, 2'b11, 5'd2), 0);
    ex_ready = 1'b0; flush = 1'b1; id_valid = 1'b1; instr = ins(7'h00, 5'd3, 5'd0, 5'd0, 10'd0);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    chk("flush_stall_ctl", 64'({ex_valid, write, branch}), 64'd0);
    $display("[TB] flush during stall ex_valid=%b write=%b branch=%b", ex_valid, write, branch);
    ex_ready = 1'b1;
    @(negedge clk);
    chk("flush_entry_ctl", 64'({ex_valid, write, branch}), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0;

    // Asynchronous reset mid-stream clears ID/EX at once and empties the RF.
    send("pre_rst", ins(7'h50, 5'd3, 5'd0, 5'd0, 10'd0), ex(0, 0, 32'h00000C00, 4'd0, 1, 0, 1, 2'b11, 5'd3), 0);
    ex_ready = 1'b0;
    void'(sb.pop_back());
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", 64'({ex_valid, write, branch}), 64'd0);
    $display("[TB] async reset ex_valid=%b write=%b branch=%b", ex_valid, write, branch);
    @(posedge clk); #1;
    rst_n = 1'b1; ex_ready = 1'b1;
    send("post_rst", ins(7'h00, 5'd4, 5'd3, 5'd5, 10'd0), ex(0, 0, 32'h00001400, 4'd0, 0, 0, 1, 2'b00, 5'd4), 0);

    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
